sdram_wr_burst: RTL and testbench
=================================

// Module: sdram_wr_burst
// PURPOSE
// - Drains the SDRAM write-path FIFO and turns its contents into fixed-length write bursts for the SDRAM command engine.
// - Sits downstream of the write FIFO read port and upstream of the command engine.
// - Tracks a linear write address inside a configurable ring region.
// - Issues a burst once a full burst of words is buffered.
// PARAMETERS
// - DATA_WIDTH  16  FIFO/SDRAM data width
// - ADDR_WIDTH  24  SDRAM word address width
// - NUM_WIDTH   10  width of FIFO rd_use_num
// - BURST_LEN   8   words per normal burst (1..256)
// - LEN_WIDTH   9   width of sdram_wr_len; must hold BURST_LEN
// - FLUSH_WAIT  64  idle cycles before a partial flush (SDRAM_WR_FLUSH_EN only)
// PORTS
// - clk                in   1           single clock (FIFO read side and SDRAM side)
// - clr                in   1           synchronous, active-high reset
// - cfg_base_addr      in   ADDR_WIDTH  ring start address (word)
// - cfg_end_addr       in   ADDR_WIDTH  ring last address (inclusive)
// - fifo_rd_req        out  1           FIFO pop; rd_data is valid 1 cycle later
// - fifo_rd_data       in   DATA_WIDTH  FIFO read data
// - fifo_rd_use_num    in   NUM_WIDTH   FIFO fill level
// - fifo_rd_empty      in   1           FIFO empty
// - sdram_wr_req       out  1           burst request, held until ack
// - sdram_wr_ack       in   1           command engine accepted request
// - sdram_wr_addr      out  ADDR_WIDTH  burst start address, stable while req/busy
// - sdram_wr_len       out  LEN_WIDTH   burst length in words, stable while req/busy
// - sdram_wr_data_req  in   1           engine wants a word; it samples sdram_wr_data the next cycle
// - sdram_wr_data      out  DATA_WIDTH  = fifo_rd_data (pass-through)
// - sdram_wr_done      in   1           engine finished the burst
// - busy               out  1           FSM not in IDLE
// - underrun           out  1           sticky: a data_req arrived while the FIFO was empty
// BEHAVIOUR
// - Reset values:
//   - FSM=IDLE, sdram_wr_req=0, fifo_rd_req=0, busy=0, underrun=0
//   - sdram_wr_addr=cfg_base_addr (sampled in the clr cycle), sdram_wr_len=BURST_LEN, beat_cnt=0
// - FSM IDLE -> REQ:
//   - when fifo_rd_use_num >= BURST_LEN.
//   - Latch len=BURST_LEN and assert sdram_wr_req on the next cycle.
// - FSM REQ -> DATA:
//   - on the cycle sdram_wr_ack=1, deassert sdram_wr_req.
//   - Req/ack in the same cycle as entry is legal; minimum 1 cycle in REQ.
// - DATA:
//   - fifo_rd_req = sdram_wr_data_req && (beat_cnt < len) && !fifo_rd_empty (combinational).
//   - beat_cnt increments on every data_req while beat_cnt < len.
//   - Extra data_req beyond len is ignored (no pop).
// - Underrun:
//   - data_req with beat_cnt < len and fifo_rd_empty sets underrun and still counts the beat.
//   - underrun clears only on clr.
// - DATA -> DONE:
//   - when sdram_wr_done=1.
//   - done before beat_cnt==len also sets underrun.
// - DONE -> IDLE (1 cycle):
//   - next = addr + len.
//   - If next > cfg_end_addr or next wraps ADDR_WIDTH: addr = cfg_base_addr, else addr = next.
//   - beat_cnt = 0.
// - No new request while busy; at most one burst outstanding.
// - clr mid-burst: immediate return to IDLE, all outputs to reset values, remaining words stay in the FIFO.
// CONFIGURATION
// - `SDRAM_WR_FLUSH_EN defined:
//   - In IDLE with 0 < use_num < BURST_LEN, an idle counter counts up; it clears on any use_num change or state exit.
//   - At FLUSH_WAIT the block issues a burst with len = use_num.
//   - Address advance uses that len.
// - `SDRAM_WR_FLUSH_EN undefined:
//   - partial data waits indefinitely; no counter logic is present.
// STRUCTURE
// - Shared package/include (sdram_wr_defs.v):
//   - state encodings WR_IDLE=2'd0, WR_REQ=2'd1, WR_DATA=2'd2, WR_DONE=2'd3
//   - default BURST_LEN
// - Sub-module sdram_wr_flush_timer (only with SDRAM_WR_FLUSH_EN): idle counter with terminal pulse.
// TESTING
// - Bench uses the existing fifo (DATA_DEPTH 10) with a behavioural command engine.
// - 1. Push 8 words 0x0001..0x0008, base=0x000000:
//   - req asserts, ack after 3 cycles, 8 data_reqs.
//   - Engine captures 0x0001..0x0008; next addr=0x000008.
// - 2. base=0x000100, end=0x00010F, push 24 words:
//   - bursts at 0x100, 0x108, then 0x100 again (wrap); no underrun.
// - 3. Push 5 words only:
//   - no sdram_wr_req for 200 cycles (flush macro off).
//   - With SDRAM_WR_FLUSH_EN, FLUSH_WAIT=64: req at cycle ~65 with len=5.
// - 4. Engine issues 10 data_reqs on an 8-word burst:
//   - exactly 8 pops, use_num drops by 8, underrun=0.
// - 5. Push 8 words, clear the FIFO after ack, engine sends data_reqs:
//   - underrun=1 and stays set until clr.
// - 6. Assert clr for 1 cycle mid-DATA (after 3 beats):
//   - busy=0 and req=0 next cycle, addr=base.
//   - The next burst starts with word 4.

Source files
------------

// File: rtl/sdram_wr_pkg.sv
// Shared definitions for the SDRAM write-burst path: FSM state encodings and
// the default burst length.
package sdram_wr_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_DATA = 2'd2,
    WR_DONE = 2'd3
  } wr_state_t;

  localparam int DEFAULT_BURST_LEN = 8;

endpackage

// File: rtl/sdram_wr_flush_timer.sv
// Idle counter for partial-burst flushing: counts cycles with a stable,
// armed fill level and emits a one-cycle fire pulse after FLUSH_WAIT cycles.
module sdram_wr_flush_timer #(
  parameter int NUM_WIDTH  = 10,
  parameter int FLUSH_WAIT = 64
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 arm,
  input  logic [NUM_WIDTH-1:0] level,
  output logic                 fire
);

  localparam int CNT_WIDTH = $clog2(FLUSH_WAIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FLUSH_WAIT - 1);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [NUM_WIDTH-1:0] level_reg;
  logic                 level_stable;

  assign level_stable = (level == level_reg);
  assign fire         = arm && level_stable && (cnt_reg == CNT_LAST);

  // Any change of the fill level restarts the wait from zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg   <= '0;
      level_reg <= '0;
    end else begin
      level_reg <= level;
      if (!arm || !level_stable || fire) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_wr_burst.sv
// Drains the SDRAM write FIFO into fixed-length write bursts inside a ring
// address region. Optional partial flush is enabled by SDRAM_WR_FLUSH_EN.
module sdram_wr_burst
  import sdram_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24,
  parameter int NUM_WIDTH  = 10,
  parameter int BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int LEN_WIDTH  = 9,
  parameter int FLUSH_WAIT = 64
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_end_addr,
  output logic                  fifo_rd_req,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic [NUM_WIDTH-1:0]  fifo_rd_use_num,
  input  logic                  fifo_rd_empty,
  output logic                  sdram_wr_req,
  input  logic                  sdram_wr_ack,
  output logic [ADDR_WIDTH-1:0] sdram_wr_addr,
  output logic [LEN_WIDTH-1:0]  sdram_wr_len,
  input  logic                  sdram_wr_data_req,
  output logic [DATA_WIDTH-1:0] sdram_wr_data,
  input  logic                  sdram_wr_done,
  output logic                  busy,
  output logic                  underrun
);

  localparam logic [NUM_WIDTH-1:0] BURST_NUM = NUM_WIDTH'(BURST_LEN);
  localparam logic [LEN_WIDTH-1:0] BURST_LEN_L = LEN_WIDTH'(BURST_LEN);

  wr_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  beat_cnt_reg, beat_cnt_next;
  logic                  underrun_reg;

  logic                  start_full;
  logic                  start_flush;
  logic [LEN_WIDTH-1:0]  flush_len;
  logic                  data_beat;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic                  addr_wrap;

  assign start_full = (fifo_rd_use_num >= BURST_NUM);

`ifdef SDRAM_WR_FLUSH_EN
  logic flush_arm;

  assign flush_arm = (state_reg == WR_IDLE) && (fifo_rd_use_num != '0)
                     && (fifo_rd_use_num < BURST_NUM);
  assign flush_len = LEN_WIDTH'(fifo_rd_use_num);

  sdram_wr_flush_timer #(
    .NUM_WIDTH  (NUM_WIDTH),
    .FLUSH_WAIT (FLUSH_WAIT)
  ) u_flush_timer (
    .clk   (clk),
    .clr   (clr),
    .arm   (flush_arm),
    .level (fifo_rd_use_num),
    .fire  (start_flush)
  );
`else
  assign start_flush = 1'b0;
  assign flush_len   = BURST_LEN_L;
`endif

  // A beat counts whenever the engine asks inside the burst, even if the
  // FIFO cannot supply a word; surplus requests past len are dropped.
  assign data_beat     = (state_reg == WR_DATA) && sdram_wr_data_req && (beat_cnt_reg < len_reg);
  assign beat_cnt_next = data_beat ? beat_cnt_reg + 1'b1 : beat_cnt_reg;

  // One extra bit catches wrap past the top of the address space.
  assign addr_sum  = {1'b0, addr_reg} + (ADDR_WIDTH + 1)'(len_reg);
  assign addr_wrap = addr_sum[ADDR_WIDTH] || (addr_sum[ADDR_WIDTH-1:0] > cfg_end_addr);

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= WR_IDLE;
      addr_reg     <= cfg_base_addr;
      len_reg      <= BURST_LEN_L;
      beat_cnt_reg <= '0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        WR_IDLE: begin
          if (start_full) begin
            len_reg <= BURST_LEN_L;
          end else if (start_flush) begin
            len_reg <= flush_len;
          end
        end
        WR_DATA: begin
          beat_cnt_reg <= beat_cnt_next;
          if ((data_beat && fifo_rd_empty) || (sdram_wr_done && (beat_cnt_next < len_reg))) begin
            underrun_reg <= 1'b1;
          end
        end
        WR_DONE: begin
          addr_reg     <= addr_wrap ? cfg_base_addr : addr_sum[ADDR_WIDTH-1:0];
          beat_cnt_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WR_IDLE: if (start_full || start_flush) state_next = WR_REQ;
      WR_REQ:  if (sdram_wr_ack) state_next = WR_DATA;
      WR_DATA: if (sdram_wr_done) state_next = WR_DONE;
      WR_DONE: state_next = WR_IDLE;
      default: state_next = WR_IDLE;
    endcase
  end

  always_comb begin
    sdram_wr_req = (state_reg == WR_REQ);
    busy         = (state_reg != WR_IDLE);
    fifo_rd_req  = data_beat && !fifo_rd_empty;
  end

  assign sdram_wr_addr = addr_reg;
  assign sdram_wr_len  = len_reg;
  assign sdram_wr_data = fifo_rd_data;
  assign underrun      = underrun_reg;

endmodule

// File: tb/tb_sdram_wr_burst.sv
// Directed bench for sdram_wr_burst: behavioural FIFO with one-cycle read
// latency plus a task-driven command engine.
module tb_sdram_wr_burst;

  logic        clk = 1'b0;
  logic        clr;
  logic [23:0] cfg_base_addr, cfg_end_addr;
  logic        fifo_rd_req;
  logic [15:0] fifo_rd_data = '0;
  logic [9:0]  fifo_rd_use_num;
  logic        fifo_rd_empty;
  logic        sdram_wr_req, sdram_wr_ack, sdram_wr_data_req, sdram_wr_done;
  logic [23:0] sdram_wr_addr;
  logic [8:0]  sdram_wr_len;
  logic [15:0] sdram_wr_data;
  logic        busy, underrun;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_wr_burst dut (
    .clk               (clk),
    .clr               (clr),
    .cfg_base_addr     (cfg_base_addr),
    .cfg_end_addr      (cfg_end_addr),
    .fifo_rd_req       (fifo_rd_req),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_rd_use_num   (fifo_rd_use_num),
    .fifo_rd_empty     (fifo_rd_empty),
    .sdram_wr_req      (sdram_wr_req),
    .sdram_wr_ack      (sdram_wr_ack),
    .sdram_wr_addr     (sdram_wr_addr),
    .sdram_wr_len      (sdram_wr_len),
    .sdram_wr_data_req (sdram_wr_data_req),
    .sdram_wr_data     (sdram_wr_data),
    .sdram_wr_done     (sdram_wr_done),
    .busy              (busy),
    .underrun          (underrun)
  );

  // Behavioural FIFO: rd_data valid the cycle after a pop
  logic [15:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  logic        push_en = 1'b0;
  logic        fifo_clear = 1'b0;
  logic [15:0] push_data = '0;
  logic [15:0] cap [0:15];

  assign fifo_rd_use_num = 10'(wr_ptr - rd_ptr);
  assign fifo_rd_empty   = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_clear) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_en) begin
        mem[wr_ptr % 1024] <= push_data;
        wr_ptr <= wr_ptr + 1;
      end
      if (fifo_rd_req && (wr_ptr != rd_ptr)) begin
        fifo_rd_data <= mem[rd_ptr % 1024];
        rd_ptr  <= rd_ptr + 1;
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  task automatic do_clr(input logic [23:0] base, input logic [23:0] last);
    @(negedge clk);
    cfg_base_addr = base;
    cfg_end_addr  = last;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic flush_fifo();
    @(negedge clk);
    fifo_clear = 1'b1;
    @(negedge clk);
    fifo_clear = 1'b0;
  endtask

  task automatic push_words(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_en   = 1'b1;
      push_data = first + 16'(i);
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic wait_req(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sdram_wr_req) begin
        ok = 1'b1;
        $display("burst request addr=%h len=%0d", sdram_wr_addr, sdram_wr_len);
        break;
      end
    end
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    sdram_wr_ack = 1'b1;
    @(negedge clk);
    sdram_wr_ack = 1'b0;
  endtask

  task automatic data_beats(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) cap[i-1] = sdram_wr_data;
      sdram_wr_data_req = (i < n);
    end
  endtask

  task automatic do_done();
    @(negedge clk);
    sdram_wr_done = 1'b1;
    @(negedge clk);
    sdram_wr_done = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; cfg_base_addr = 24'h000040; cfg_end_addr = 24'hFFFFFF;
    sdram_wr_ack = 1'b0; sdram_wr_data_req = 1'b0; sdram_wr_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", sdram_wr_req); end
    n_cmp++; if (fifo_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b want 0", fifo_rd_req); end
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_cmp++; if (sdram_wr_addr !== 24'h000040) begin n_fail++; $display("FAIL reset_addr: got %h want 000040", sdram_wr_addr); end
    n_cmp++; if (sdram_wr_len !== 9'd8) begin n_fail++; $display("FAIL reset_len: got %0d want 8", sdram_wr_len); end
    clr = 1'b0;
  endtask

  task automatic test_single_burst();
    bit ok;
    do_clr(24'h000000, 24'hFFFFFF);
    push_words(16'h0001, 8);
    wait_req(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_req: got timeout want req"); end
    n_cmp++; if (sdram_wr_addr !== 24'h000000) begin n_fail++; $display("FAIL single_addr: got %h want 000000", sdram_wr_addr); end
    n_cmp++; if (sdram_wr_len !== 9'd8) begin n_fail++; $display("FAIL single_len: got %0d want 8", sdram_wr_len); end
    do_ack(3);
    n_cmp++; if (sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b want 0", sdram_wr_req); end
    data_beats(8);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (cap[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, cap[i], 16'(i + 1)); end
    end
    do_done();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
    n_cmp++; if (sdram_wr_addr !== 24'h000008) begin n_fail++; $display("FAIL single_next_addr: got %h want 000008", sdram_wr_addr); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [23:0] exp_addr [0:2];
    exp_addr[0] = 24'h000100; exp_addr[1] = 24'h000108; exp_addr[2] = 24'h000100;
    do_clr(24'h000100, 24'h00010F);
    push_words(16'h0101, 24);
    for (int b = 0; b < 3; b++) begin
      wait_req(100, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_req%0d: got timeout want req", b); end
      n_cmp++; if (sdram_wr_addr !== exp_addr[b]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", b, sdram_wr_addr, exp_addr[b]); end
      do_ack(1);
      data_beats(8);
      n_cmp++; if (cap[0] !== 16'(16'h0101 + 8 * b)) begin n_fail++; $display("FAIL wrap_first%0d: got %h want %h", b, cap[0], 16'(16'h0101 + 8 * b)); end
      n_cmp++; if (cap[7] !== 16'(16'h0108 + 8 * b)) begin n_fail++; $display("FAIL wrap_last%0d: got %h want %h", b, cap[7], 16'(16'h0108 + 8 * b)); end
      do_done();
    end
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL wrap_underrun: got %b want 0", underrun); end
    n_cmp++; if (sdram_wr_addr !== 24'h000108) begin n_fail++; $display("FAIL wrap_final_addr: got %h want 000108", sdram_wr_addr); end
  endtask

  task automatic test_partial();
    do_clr(24'h000000, 24'hFFFFFF);
    push_words(16'h0301, 5);
`ifdef SDRAM_WR_FLUSH_EN
    begin
      bit ok;
      wait_req(100, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL partial_flush_req: got timeout want req"); end
      n_cmp++; if (sdram_wr_len !== 9'd5) begin n_fail++; $display("FAIL partial_flush_len: got %0d want 5", sdram_wr_len); end
      do_ack(1);
      data_beats(5);
      do_done();
      @(negedge clk);
      n_cmp++; if (sdram_wr_addr !== 24'h000005) begin n_fail++; $display("FAIL partial_flush_addr: got %h want 000005", sdram_wr_addr); end
    end
`else
    begin
      int seen = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (sdram_wr_req || busy) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL partial_no_req: got %0d active cycles want 0", seen); end
      $display("partial hold: 5 words waited 200 cycles without a burst");
    end
`endif
    flush_fifo();
  endtask

  task automatic test_extra_data_req();
    bit ok;
    int pops_before;
    do_clr(24'h000000, 24'hFFFFFF);
    pops_before = pop_cnt;
    push_words(16'h0201, 10);
    wait_req(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL extra_req: got timeout want req"); end
    do_ack(1);
    data_beats(10);
    do_done();
    @(negedge clk);
    n_cmp++; if (pop_cnt - pops_before !== 8) begin n_fail++; $display("FAIL extra_pops: got %0d want 8", pop_cnt - pops_before); end
    n_cmp++; if (fifo_rd_use_num !== 10'd2) begin n_fail++; $display("FAIL extra_use_num: got %0d want 2", fifo_rd_use_num); end
    n_cmp++; if (cap[7] !== 16'h0208) begin n_fail++; $display("FAIL extra_last: got %h want 0208", cap[7]); end
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL extra_underrun: got %b want 0", underrun); end
    flush_fifo();
  endtask

  task automatic test_underrun();
    bit ok;
    do_clr(24'h000000, 24'hFFFFFF);
    push_words(16'h0401, 8);
    wait_req(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL under_req: got timeout want req"); end
    do_ack(2);
    flush_fifo();
    data_beats(8);
    do_done();
    @(negedge clk);
    n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL under_set: got %b want 1", underrun); end
    repeat (20) @(negedge clk);
    n_cmp++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL under_sticky: got %b want 1", underrun); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL under_busy: got %b want 0", busy); end
    do_clr(24'h000000, 24'hFFFFFF);
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL under_clr: got %b want 0", underrun); end
  endtask

  task automatic test_clr_mid_burst();
    bit ok;
    do_clr(24'h000200, 24'hFFFFFF);
    push_words(16'h0A01, 8);
    wait_req(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midclr_req: got timeout want req"); end
    do_ack(1);
    data_beats(3);
    do_clr(24'h000200, 24'hFFFFFF);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy: got %b want 0", busy); end
    n_cmp++; if (sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL midclr_req_low: got %b want 0", sdram_wr_req); end
    n_cmp++; if (sdram_wr_addr !== 24'h000200) begin n_fail++; $display("FAIL midclr_addr: got %h want 000200", sdram_wr_addr); end
    n_cmp++; if (fifo_rd_use_num !== 10'd5) begin n_fail++; $display("FAIL midclr_left: got %0d want 5", fifo_rd_use_num); end
    push_words(16'h0B01, 3);
    wait_req(100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midclr_req2: got timeout want req"); end
    n_cmp++; if (sdram_wr_addr !== 24'h000200) begin n_fail++; $display("FAIL midclr_addr2: got %h want 000200", sdram_wr_addr); end
    do_ack(1);
    data_beats(8);
    n_cmp++; if (cap[0] !== 16'h0A04) begin n_fail++; $display("FAIL midclr_first: got %h want 0A04", cap[0]); end
    n_cmp++; if (cap[7] !== 16'h0B03) begin n_fail++; $display("FAIL midclr_last: got %h want 0B03", cap[7]); end
    do_done();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_wrap();
    test_partial();
    test_extra_data_req();
    test_underrun();
    test_clr_mid_burst();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
